// File: rtl/sad_pkg.sv
// Shared definitions for the SAD motion-search controller: default widths,
// the PE pipeline latency and the controller state encoding.
package sad_pkg;

  // Width of the SAD value produced by the processing element.
  localparam int SAD_W = 12;

  // Default search half-range; displacements span -RANGE..RANGE-1.
  localparam int DEFAULT_RANGE = 8;

  // Cycles from a pe_enable cycle to the cycle its pe_sum is presented.
  localparam int PE_LAT = 2;

  // Controller states. DONE is held for exactly one cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } sad_state_e;

endpackage

// File: rtl/sad_tag_pipe.sv
// Latency-matched delay line carrying a valid bit and the candidate
// coordinates alongside the PE, so each pe_sum can be paired with the
// candidate that produced it.
//
// Stage 0 is loaded from the inputs; stage LAT-1 is presented on the
// outputs. pending_o reports entries that have not yet reached the last
// stage, i.e. work that will still emerge after the next edge. LAT must be
// at least 2.
module sad_tag_pipe #(
  parameter int CW  = 4,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  output logic          valid_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          pending_o
);

  // Selects every stage except the output stage.
  localparam logic [LAT-1:0] UP_MASK = LAT'((1 << (LAT - 1)) - 1);

  logic [LAT-1:0]         vld_q, vld_d;
  logic [LAT-1:0][CW-1:0] x_q, x_d;
  logic [LAT-1:0][CW-1:0] y_q, y_d;

  // Shift every stage one step toward the output each cycle.
  always_comb begin
    vld_d    = vld_q;
    x_d      = x_q;
    y_d      = y_q;
    vld_d[0] = valid_i;
    x_d[0]   = x_i;
    y_d[0]   = y_i;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      x_d[i]   = x_q[i-1];
      y_d[i]   = y_q[i-1];
    end
  end

  // Pipe registers; reset empties the pipe so late PE results are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      vld_q <= vld_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign valid_o   = vld_q[LAT-1];
  assign x_o       = x_q[LAT-1];
  assign y_o       = y_q[LAT-1];
  assign pending_o = |(vld_q & UP_MASK);

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search block-matching controller. Walks every candidate offset of a
// (2*RANGE)x(2*RANGE) window in raster order (x inner, y outer), drives an
// external PE, and tracks the minimum SAD and its displacement.
//
// Handshake: a candidate is issued in any SEARCH cycle where win_ready=1;
// that cycle has pe_enable=1 and cand_x/cand_y hold the candidate. When
// win_ready=0 nothing is issued and the counters hold. The PE result for an
// issued candidate is sampled PE_LAT cycles later on the matching tag.
// start is a one-cycle request honoured only in IDLE; done is a one-cycle
// pulse after which best_* stay stable until the next accepted start.
module sad_search_ctrl #(
  parameter  int RANGE = sad_pkg::DEFAULT_RANGE,
  parameter  int SAD_W = sad_pkg::SAD_W,
  localparam int CW    = $clog2(2 * RANGE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                win_ready,
  output logic                pe_enable,
  output logic [CW-1:0]       cand_x,
  output logic [CW-1:0]       cand_y,
  input  logic [SAD_W-1:0]    pe_sum,
  output logic                busy,
  output logic                done,
  output logic [SAD_W-1:0]    best_sad,
  output logic signed [CW-1:0] best_mvx,
  output logic signed [CW-1:0] best_mvy,
  output logic [1:0]          dbg_state
);

  import sad_pkg::*;

  // Last counter value on each axis (2*RANGE-1 is all-ones for a power of two).
  localparam logic [CW-1:0] CNT_MAX = '1;
  // Offset subtracted from a window coordinate to get a signed displacement.
  localparam logic [CW-1:0] RANGE_C = CW'(RANGE);

  sad_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_x_q, cnt_x_d;
  logic [CW-1:0]    cnt_y_q, cnt_y_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [CW-1:0]    best_mvx_q, best_mvx_d;
  logic [CW-1:0]    best_mvy_q, best_mvy_d;

  logic             accept;
  logic             issue;
  logic             last_issue;
  logic             tag_valid;
  logic             tag_pending;
  logic [CW-1:0]    tag_x;
  logic [CW-1:0]    tag_y;

  assign accept     = (state_q == IDLE) && start;
  assign issue      = (state_q == SEARCH) && win_ready;
  assign last_issue = issue && (cnt_x_q == CNT_MAX) && (cnt_y_q == CNT_MAX);

  // Carries each issued candidate alongside the PE so results can be tagged.
  sad_tag_pipe #(
    .CW  (CW),
    .LAT (PE_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (issue),
    .x_i       (cnt_x_q),
    .y_i       (cnt_y_q),
    .valid_o   (tag_valid),
    .x_o       (tag_x),
    .y_o       (tag_y),
    .pending_o (tag_pending)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DRAIN waits until no entry will still emerge from the pipe,
  // so the final compare and the move to DONE land on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SEARCH;
      SEARCH:  if (last_issue) state_d = DRAIN;
      DRAIN:   if (!tag_pending) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    pe_enable = issue;
    busy      = (state_q == SEARCH) || (state_q == DRAIN);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Candidate counters: cleared on accept, advance only on an issued candidate.
  always_comb begin
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    if (accept) begin
      cnt_x_d = '0;
      cnt_y_d = '0;
    end else if (issue) begin
      if (cnt_x_q == CNT_MAX) begin
        cnt_x_d = '0;
        cnt_y_d = cnt_y_q + 1'b1;
      end else begin
        cnt_x_d = cnt_x_q + 1'b1;
      end
    end
  end

  // Best-match tracking: strict less-than keeps the earliest raster candidate on ties.
  always_comb begin
    best_sad_d = best_sad_q;
    best_mvx_d = best_mvx_q;
    best_mvy_d = best_mvy_q;
    if (accept) begin
      best_sad_d = '1;
      best_mvx_d = '0;
      best_mvy_d = '0;
    end else if (tag_valid && (pe_sum < best_sad_q)) begin
      best_sad_d = pe_sum;
      best_mvx_d = tag_x - RANGE_C;
      best_mvy_d = tag_y - RANGE_C;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      best_sad_q <= '1;
      best_mvx_q <= '0;
      best_mvy_q <= '0;
    end else begin
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
      best_sad_q <= best_sad_d;
      best_mvx_q <= best_mvx_d;
      best_mvy_q <= best_mvy_d;
    end
  end

  assign cand_x   = cnt_x_q;
  assign cand_y   = cnt_y_q;
  assign best_sad = best_sad_q;
  assign best_mvx = best_mvx_q;
  assign best_mvy = best_mvy_q;

endmodule

// File: doc/sad_search_ctrl.md
SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 The block SHALL have parameter RANGE, default 8, meaning search half-range (power of two, 2..32); displacements span -RANGE..RANGE-1 on each axis.
REQ-002 The block SHALL have parameter SAD_W, default 12, meaning PE sum width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a search.
REQ-006 The block SHALL have port win_ready, input, 1 bit: window buffer can present pixels for the current candidate this cycle.
REQ-007 The block SHALL have port pe_enable, output, 1 bit: drives the PE enable input.
REQ-008 The block SHALL have ports cand_x and cand_y, output, $clog2(2*RANGE) bits each: unsigned candidate offset within the search window.
REQ-009 The block SHALL have port pe_sum, input, SAD_W bits: PE sum output.
REQ-010 The block SHALL have port busy, output, 1 bit: search in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse; results valid.
REQ-012 The block SHALL have port best_sad, output, SAD_W bits: minimum SAD found.
REQ-013 The block SHALL have ports best_mvx and best_mvy, output, $clog2(2*RANGE) bits signed each: displacement = cand - RANGE.

Function
REQ-014 The FSM SHALL have states IDLE, SEARCH, DRAIN and DONE.
REQ-015 IDLE SHALL go to SEARCH when start=1, clearing both counters to 0 and loading best_sad with all-ones.
REQ-016 SEARCH SHALL issue one candidate per cycle with win_ready=1: pe_enable=1, cand_x/cand_y = counters, raster order (x inner, y outer).
REQ-017 pe_enable SHALL be 0 and counters SHALL hold when win_ready=0; no candidate may be skipped or repeated.
REQ-018 After the candidate (2*RANGE-1, 2*RANGE-1) issues, the FSM SHALL go to DRAIN.
REQ-019 The block SHALL carry a valid bit plus cand_x/cand_y through a 2-stage delay matching PE latency, so pe_sum is sampled exactly 2 cycles after its pe_enable cycle.
REQ-020 On a delayed-valid cycle, if pe_sum < best_sad (strict), best_sad/best_mvx/best_mvy SHALL update at that edge; on ties the earliest candidate in raster order SHALL be retained.
REQ-021 DRAIN SHALL go to DONE once the delay pipe holds no valid entries.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in SEARCH and DRAIN and 0 otherwise.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 Results SHALL hold from DONE until the next accepted start.
REQ-026 With no stalls, if start=1 in cycle 0, candidates SHALL issue in cycles 1..(2*RANGE)^2 and done SHALL be high in cycle (2*RANGE)^2+3.
REQ-027 The counter SHALL wrap the x count to 0 and increment y on the same edge.

Reset
REQ-028 While rst_n=0 at an edge, the FSM SHALL go to IDLE and the delay pipe SHALL clear.
REQ-029 While rst_n=0 at an edge, pe_enable, busy, done, cand_x, cand_y, best_mvx and best_mvy SHALL become 0, and best_sad SHALL become all-ones.
REQ-030 A reset mid-search SHALL abandon the search with no done pulse, and any PE results arriving after reset SHALL be ignored.

Structure
REQ-031 Package sad_pkg SHALL hold SAD_W, the default RANGE, the FSM state enum, and the PE latency constant (2).
REQ-032 One sub-module, sad_tag_pipe, SHALL implement the latency-matched valid+coordinate delay line.
REQ-033 The PE SHALL be instantiated outside this block.

Verification (RANGE=8, 256 candidates, PE behavioural model)
REQ-034 A PE model returning 100 everywhere except 5 at cand (3,12) SHALL yield best_sad=5, mvx=-5, mvy=+4, with done in cycle 259.
REQ-035 A PE model returning 0 everywhere SHALL yield best_sad=0, mvx=-8, mvy=-8 (first-candidate tie rule).
REQ-036 Holding win_ready=0 for 10 cycles after candidate 40 SHALL produce exactly 256 pe_enable cycles, with done in cycle 269 and an unchanged result.
REQ-037 Pulsing start in cycle 50 of a search SHALL cause no restart, exactly one done pulse, and correct results.
REQ-038 Asserting rst_n=0 at cycle 100 SHALL clear all outputs to reset values, produce no done, and cause a following start to run a clean full search.
REQ-039 A minimum of 0 at the last candidate (15,15) SHALL yield mvx=+7, mvy=+7, proving the drain captures the final results.
